// File: rtl/mux2x1_sel_arbiter.sv
// Round-robin arbiter that owns the select of a downstream 2x1 mux.
// Two requesters compete for the shared output; the winner gets a
// registered grant, the mux select follows the owner, and a hold limit
// forces a handover when the other side has been waiting too long.
// Ownership passes directly between requesters without an idle cycle.
module mux2x1_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          done0,
    input  logic          done1,
    output logic          s,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

    state_t state;
    logic   last;   // requester served most recently; the other one wins a tie
    logic   go0;    // enter G0 at the next edge
    logic   go1;    // enter G1 at the next edge
    logic   keep;   // current owner keeps the grant

    // Hold counter advances by one and sticks at the limit.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        if (cnt == HOLD_LIMIT) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // Decide the next owner from the current state, requests and releases.
    always_comb begin
        go0  = 1'b0;
        go1  = 1'b0;
        keep = 1'b0;
        case (state)
            IDLE: begin
                go0 = req0 && (!req1 || last);
                go1 = req1 && !(req0 && (!req1 || last));
            end
            G0: begin
                // A release wins over a simultaneous preempt; both hand over
                // to the other side when it is requesting.
                if (done0 || !req0) begin
                    go1 = req1;
                end else if ((hold_cnt == HOLD_LIMIT) && req1) begin
                    go1 = 1'b1;
                end else begin
                    keep = 1'b1;
                end
            end
            G1: begin
                if (done1 || !req1) begin
                    go0 = req0;
                end else if ((hold_cnt == HOLD_LIMIT) && req0) begin
                    go0 = 1'b1;
                end else begin
                    keep = 1'b1;
                end
            end
            default: begin
                go0  = 1'b0;
                go1  = 1'b0;
                keep = 1'b0;
            end
        endcase
    end

    // Register the owner, grants, select, hold count and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            s        <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else if (go0) begin
            state    <= G0;
            gnt0     <= 1'b1;
            gnt1     <= 1'b0;
            s        <= 1'b0;
            busy     <= 1'b1;
            hold_cnt <= '0;
            last     <= 1'b0;
        end else if (go1) begin
            state    <= G1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b1;
            s        <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else if (keep) begin
            hold_cnt <= sat_inc(hold_cnt);
        end else begin
            // Nobody owns the output; the select keeps its last value.
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mux2x1_sel_arbiter.sv
// Directed bench for mux2x1_sel_arbiter with hand-computed expectations.
module tb_mux2x1_sel_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CW       = 4;

    logic          clk;
    logic          rst;
    logic          req0;
    logic          req1;
    logic          done0;
    logic          done1;
    logic          s;
    logic          gnt0;
    logic          gnt1;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    mux2x1_sel_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .CW      (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .done0   (done0),
        .done1   (done1),
        .s       (s),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .hold_cnt(hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all registered outputs at once.
    task automatic chk_all(input string tag, input logic e_g0, input logic e_g1,
                           input logic e_s, input logic e_busy, input int e_hold);
        chk({tag, ".gnt0"}, {7'd0, gnt0}, {7'd0, e_g0});
        chk({tag, ".gnt1"}, {7'd0, gnt1}, {7'd0, e_g1});
        chk({tag, ".s"}, {7'd0, s}, {7'd0, e_s});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
        chk({tag, ".hold_cnt"}, {4'd0, hold_cnt}, 8'(e_hold));
    endtask

    initial begin
        rst   = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        done0 = 1'b0;
        done1 = 1'b0;

        // Reset held two cycles with both requesting.
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // First tie after reset goes to requester 0.
        rst = 1'b0;
        step();
        chk_all("first_tie", 1'b1, 1'b0, 1'b0, 1'b1, 0);

        // Both held: G0 counts 1..7, then preempted to G1.
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
            chk_all("pre_g0", 1'b1, 1'b0, 1'b0, 1'b1, i);
        end
        step();
        chk_all("preempt_to_g1", 1'b0, 1'b1, 1'b1, 1'b1, 0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
            chk_all("pre_g1", 1'b0, 1'b1, 1'b1, 1'b1, i);
        end
        step();
        chk_all("preempt_to_g0", 1'b1, 1'b0, 1'b0, 1'b1, 0);

        // Requester 0 alone for 20 cycles: counter saturates at 7.
        req1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk_all("sat_g0", 1'b1, 1'b0, 1'b0, 1'b1, (i < MAX_HOLD) ? i : MAX_HOLD - 1);
        end
        req1 = 1'b1;
        step();
        chk_all("sat_handover", 1'b0, 1'b1, 1'b1, 1'b1, 0);

        // Requester 1 alone, then releases with done1.
        req0 = 1'b0;
        step();
        chk_all("single_g1_1", 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step();
        chk_all("single_g1_2", 1'b0, 1'b1, 1'b1, 1'b1, 2);
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        req1  = 1'b0;
        chk_all("release_idle", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        chk_all("idle_hold_s", 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Requester 0 alone from IDLE; stray done1 has no effect.
        req0 = 1'b1;
        step();
        chk_all("single_g0", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        chk_all("stray_done1", 1'b1, 1'b0, 1'b0, 1'b1, 1);

        // Back-to-back handover on done0 while requester 1 waits.
        req1  = 1'b1;
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        chk_all("b2b_handover", 1'b0, 1'b1, 1'b1, 1'b1, 0);
        step();
        chk_all("g1_after_b2b", 1'b0, 1'b1, 1'b1, 1'b1, 1);

        // Reset mid-grant, then the next tie goes to requester 0 again.
        rst = 1'b1;
        step();
        chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        step();
        chk_all("tie_after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 0);

        // Request dropped on the grant-arrival cycle counts as a release.
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk_all("drop_on_arrival", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Tie after requester 0 was last served goes to requester 1.
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        chk_all("tie_rr_to_1", 1'b0, 1'b1, 1'b1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
